// File: rtl/qed_replay_queue_if.sv
// Capture/replay handshake bundle for qed_replay_queue.
// The bench or wrapper drives it through the master modport; the queue uses the slave modport.
interface qed_replay_queue_if #(
    parameter int ILEN  = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            ena;
    logic            exec_dup;
    logic            stall_IF;
    logic            ifu_qed_vld;
    logic [ILEN-1:0] ifu_qed_instruction;
    logic            dup_rdy;
    logic [ILEN-1:0] qic_qimux_instruction;
    logic            vld_out;
    logic            qed_mode_dup;
    logic            qed_full;
    logic [CW-1:0]   qed_count;

    modport master (
        output ena, exec_dup, stall_IF, ifu_qed_vld, ifu_qed_instruction, dup_rdy,
        input  qic_qimux_instruction, vld_out, qed_mode_dup, qed_full, qed_count
    );

    modport slave (
        input  ena, exec_dup, stall_IF, ifu_qed_vld, ifu_qed_instruction, dup_rdy,
        output qic_qimux_instruction, vld_out, qed_mode_dup, qed_full, qed_count
    );
endinterface

// File: rtl/qed_replay_queue.sv
// QED replay queue: captures original IFU instructions in a circular buffer and replays them in order.
// Optional QED_CTRL_SYNC_EN: control-flow instructions are not stored and force duplicate replay first.
module qed_replay_queue #(
    parameter int ILEN        = 32,
    parameter int DEPTH       = 8,
    parameter int AUTO_SWITCH = 1
) (
    input  logic                clk,
    input  logic                rst,
    qed_replay_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ORIG = 2'd1;
    localparam logic [1:0] S_DUP  = 2'd2;

    logic [1:0]      state_q,  state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [ILEN-1:0] mem_q [DEPTH];

    logic full;
    logic ctrl;
    logic cap;
    logic store;
    logic vld;
    logic xfer;
    logic go_dup;

`ifdef QED_CTRL_SYNC_EN
    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == 7'b1100011) || (op == 7'b1101111) ||
               (op == 7'b1100111) || (op == 7'b1110011);
    endfunction

    assign ctrl = is_ctrl(bus.ifu_qed_instruction[6:0]);
`else
    assign ctrl = 1'b0;
`endif

    assign full  = (count_q == CW'(DEPTH));
    assign cap   = bus.ena & ~bus.stall_IF & (state_q == S_ORIG) & bus.ifu_qed_vld & ~full;
    assign store = cap & ~ctrl;
    assign vld   = (state_q == S_DUP) & (count_q != '0) & ~bus.stall_IF;
    assign xfer  = bus.ena & vld & bus.dup_rdy;

    // A capture on the switching edge is counted before the full check, so it joins the replay.
    assign go_dup = (bus.exec_dup & (count_q != '0)) |
                    ((AUTO_SWITCH != 0) & (count_d == CW'(DEPTH))) |
                    (cap & ctrl & (count_q != '0));

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!bus.ena) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (!bus.stall_IF) begin
            case (state_q)
                S_IDLE: state_d = S_ORIG;
                S_ORIG: begin
                    if (store) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end
                end
                S_DUP: begin
                    if (xfer) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                        if (count_q == CW'(1)) state_d = S_ORIG;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if ((state_q == S_ORIG) && go_dup) state_d = S_DUP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q] <= bus.ifu_qed_instruction;
    end

    // Head view is gated so the unreset buffer never leaks onto the output outside replay.
    assign bus.qic_qimux_instruction = ((state_q == S_DUP) && (count_q != '0)) ? mem_q[rd_ptr_q] : '0;
    assign bus.vld_out      = vld;
    assign bus.qed_mode_dup = (state_q == S_DUP);
    assign bus.qed_full     = full;
    assign bus.qed_count    = count_q;
endmodule

// File: tb/tb_qed_replay_queue.sv
// Directed bench for qed_replay_queue with a queue-based reference model checked every cycle.
module tb_qed_replay_queue;
    localparam int ILEN  = 32;
    localparam int DEPTH = 8;
`ifdef QED_CTRL_SYNC_EN
    localparam bit CTRL_SYNC = 1'b1;
`else
    localparam bit CTRL_SYNC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    qed_replay_queue_if #(.ILEN(ILEN), .DEPTH(DEPTH)) bus ();

    qed_replay_queue #(.ILEN(ILEN), .DEPTH(DEPTH), .AUTO_SWITCH(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_ctrl(input logic [31:0] w);
        return (w[6:0] == 7'b1100011) || (w[6:0] == 7'b1101111) ||
               (w[6:0] == 7'b1100111) || (w[6:0] == 7'b1110011);
    endfunction

    // Reference model: mode 0=IDLE 1=ORIG 2=DUP, contents held as an ordered queue.
    int          m_mode = 0;
    logic [31:0] m_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0;
            m_q.delete();
        end else if (!bus.ena) begin
            m_mode = 0;
            m_q.delete();
        end else if (!bus.stall_IF) begin
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                int  prev;
                bit  take, is_c;
                prev = m_q.size();
                take = bus.ifu_qed_vld && (prev < DEPTH);
                is_c = CTRL_SYNC && is_ctrl(bus.ifu_qed_instruction);
                if (take && !is_c) m_q.push_back(bus.ifu_qed_instruction);
                if ((bus.exec_dup && prev > 0) || (m_q.size() == DEPTH) || (take && is_c && prev > 0))
                    m_mode = 2;
            end else begin
                if (m_q.size() > 0 && bus.dup_rdy) void'(m_q.pop_front());
                if (m_q.size() == 0) m_mode = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("vld_out", {31'd0, bus.vld_out}, {31'd0, (m_mode == 2) && (m_q.size() > 0) && !bus.stall_IF});
            check("mode_dup", {31'd0, bus.qed_mode_dup}, {31'd0, m_mode == 2});
            check("full", {31'd0, bus.qed_full}, {31'd0, m_q.size() == DEPTH});
            check("count", 32'(bus.qed_count), 32'(m_q.size()));
            if (m_mode == 2 && m_q.size() > 0)
                check("head", bus.qic_qimux_instruction, m_q[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] w);
        bus.ifu_qed_vld         = 1'b1;
        bus.ifu_qed_instruction = w;
        tick();
        bus.ifu_qed_vld = 1'b0;
    endtask

    task automatic drain(input string name, input logic [31:0] w);
        #1;
        check({name, "_vld"}, {31'd0, bus.vld_out}, 32'd1);
        check(name, bus.qic_qimux_instruction, w);
        tick();
    endtask

    function automatic logic [31:0] alu(input int k);
        return 32'h0000_0013 | (32'(k) << 20);
    endfunction

    logic [31:0] wa [3] = '{32'h00100093, 32'h00208113, 32'h00310193};
    logic [31:0] wb [3] = '{32'h00400213, 32'h00508293, 32'h0060c313};

    initial begin
        bus.ena = 1'b0; bus.exec_dup = 1'b0; bus.stall_IF = 1'b0;
        bus.ifu_qed_vld = 1'b0; bus.ifu_qed_instruction = '0; bus.dup_rdy = 1'b0;

        repeat (2) tick();
        #1;
        check("rst_vld", {31'd0, bus.vld_out}, 32'd0);
        check("rst_count", 32'(bus.qed_count), 32'd0);
        check("rst_mode", {31'd0, bus.qed_mode_dup}, 32'd0);
        check("rst_full", {31'd0, bus.qed_full}, 32'd0);
        check("rst_instr", bus.qic_qimux_instruction, 32'd0);

        rst = 1'b1; bus.ena = 1'b1;
        tick();

        // Three captures then an explicit replay with downstream always ready.
        for (int i = 0; i < 3; i++) put(wa[i]);
        #1;
        check("a_count", 32'(bus.qed_count), 32'd3);
        check("model_a_size", 32'(m_q.size()), 32'd3);
        check("model_a_head", m_q[0], 32'h00100093);
        bus.exec_dup = 1'b1; bus.dup_rdy = 1'b1;
        tick();
        bus.exec_dup = 1'b0;
        for (int i = 0; i < 3; i++) drain($sformatf("a_rep%0d", i), wa[i]);
        #1;
        check("a_mode_end", {31'd0, bus.qed_mode_dup}, 32'd0);
        check("a_count_end", 32'(bus.qed_count), 32'd0);

        bus.dup_rdy = 1'b0;
        bus.exec_dup = 1'b1;
        tick();
        bus.exec_dup = 1'b0;
        #1;
        check("empty_exec_mode", {31'd0, bus.qed_mode_dup}, 32'd0);

        // exec_dup alongside the third capture; then backpressure and stall.
        put(wb[0]); put(wb[1]);
        bus.exec_dup = 1'b1;
        put(wb[2]);
        bus.exec_dup = 1'b0;
        #1;
        check("b_mode", {31'd0, bus.qed_mode_dup}, 32'd1);
        check("b_count", 32'(bus.qed_count), 32'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check("hold_instr", bus.qic_qimux_instruction, wb[0]);
            check("hold_count", 32'(bus.qed_count), 32'd3);
        end
        bus.stall_IF = 1'b1; bus.dup_rdy = 1'b1;
        #1;
        check("stall_vld", {31'd0, bus.vld_out}, 32'd0);
        repeat (2) tick();
        #1;
        check("stall_count", 32'(bus.qed_count), 32'd3);
        check("stall_instr", bus.qic_qimux_instruction, wb[0]);
        bus.stall_IF = 1'b0;
        for (int i = 0; i < 3; i++) drain($sformatf("b_rep%0d", i), wb[i]);

        // Two full batches; write pointer starts mid-buffer so both wrap.
        for (int b = 0; b < 2; b++) begin
            bus.dup_rdy = 1'b0;
            for (int i = 0; i < 9; i++) begin
                if (b == 1 && i == 8) break;
                put(alu(16 * b + i + 1));
                if (i == 7) begin
                    #1;
                    check("full_flag", {31'd0, bus.qed_full}, 32'd1);
                    check("full_mode", {31'd0, bus.qed_mode_dup}, 32'd1);
                end
            end
            #1;
            check("full_count", 32'(bus.qed_count), 32'd8);
            bus.dup_rdy = 1'b1;
            for (int i = 0; i < 8; i++) drain($sformatf("c%0d_rep%0d", b, i), alu(16 * b + i + 1));
            #1;
            check("full_drained", 32'(bus.qed_count), 32'd0);
        end

        // Asynchronous reset in the middle of a stalled replay.
        bus.dup_rdy = 1'b0;
        for (int i = 0; i < 3; i++) put(alu(40 + i));
        bus.exec_dup = 1'b1;
        tick();
        bus.exec_dup = 1'b0;
        #1;
        check("pre_rst_mode", {31'd0, bus.qed_mode_dup}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_vld", {31'd0, bus.vld_out}, 32'd0);
        check("mid_rst_count", 32'(bus.qed_count), 32'd0);
        check("mid_rst_mode", {31'd0, bus.qed_mode_dup}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        put(alu(50));
        #1;
        check("post_rst_capture", 32'(bus.qed_count), 32'd1);
        bus.ena = 1'b0;
        tick();
        #1;
        check("ena_clear", 32'(bus.qed_count), 32'd0);
        bus.ena = 1'b1;
        tick();

        // Control-flow instruction after two ALU ops.
        put(alu(60)); put(alu(61)); put(32'h0000006F);
        #1;
        bus.dup_rdy = 1'b1;
`ifdef QED_CTRL_SYNC_EN
        check("jal_mode", {31'd0, bus.qed_mode_dup}, 32'd1);
        check("jal_count", 32'(bus.qed_count), 32'd2);
        drain("jal_rep0", alu(60));
        drain("jal_rep1", alu(61));
        #1;
        check("jal_not_replayed", 32'(bus.qed_count), 32'd0);
        check("jal_end_mode", {31'd0, bus.qed_mode_dup}, 32'd0);
`else
        check("jal_mode", {31'd0, bus.qed_mode_dup}, 32'd0);
        check("jal_count", 32'(bus.qed_count), 32'd3);
        bus.exec_dup = 1'b1;
        tick();
        bus.exec_dup = 1'b0;
        drain("jal_rep0", alu(60));
        drain("jal_rep1", alu(61));
        drain("jal_rep2", 32'h0000006F);
        #1;
        check("jal_end_mode", {31'd0, bus.qed_mode_dup}, 32'd0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/qed_replay_queue.md
Name: qed_replay_queue

Overview:
- Parametrised successor of the QED instruction cache for the biriscv QED wrapper.
- Captures original instructions leaving the IFU in a DEPTH-entry circular buffer, then replays them in program order as duplicate-stream instructions.
- Replay output feeds the instruction modifier and instruction mux.
- Adds over the previous generation: configurable width and depth, occupancy tracking, automatic switch to duplicate mode on full, and an explicit mode FSM with replay handshake.

Parameters:
- ILEN, 32, instruction width in bits (≥ 32; opcode is bits [6:0]).
- DEPTH, 8, buffer entries; power of two, 2..64.
- AUTO_SWITCH, 1, when 1 a full buffer forces ORIG→DUP without exec_dup.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  QED enable; 0 keeps the block in IDLE.
- exec_dup  in  1  request to start duplicate replay.
- stall_IF  in  1  fetch stall; freezes capture and replay.
- ifu_qed_vld  in  1  ifu_qed_instruction is a valid fetched instruction.
- ifu_qed_instruction  in  ILEN  fetched original instruction.
- dup_rdy  in  1  downstream accepts replayed instruction.
- qic_qimux_instruction  out  ILEN  replayed instruction (head entry).
- vld_out  out  1  replay valid.
- qed_mode_dup  out  1  1 while in DUP.
- qed_full  out  1  occupancy == DEPTH.
- qed_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst=0, async), all outputs 0:
  - state=IDLE; wr_ptr, rd_ptr, count = 0.
  - vld_out, qed_mode_dup, qed_full = 0; qic_qimux_instruction = 0.
  - Buffer contents are not reset.
- FSM states: IDLE, ORIG, DUP.
  - IDLE→ORIG: ena=1.
  - ORIG→DUP: (exec_dup=1 and count>0) or (AUTO_SWITCH and count==DEPTH). exec_dup with count==0 is ignored.
  - DUP→ORIG: the last entry is accepted (count 1→0).
  - Any state→IDLE when ena=0; pointers and count clear on the same edge.
- Capture (ORIG only):
  - Condition: ifu_qed_vld & ~stall_IF & ~qed_full. Writes buf[wr_ptr], wr_ptr+1, count+1.
  - A capture and the ORIG→DUP transition can occur on the same edge; the captured entry is included in the replay.
  - Capture while full: dropped, count unchanged. Cannot occur when AUTO_SWITCH=1.
- Replay (DUP only):
  - vld_out = (state==DUP) & (count>0) & ~stall_IF.
  - qic_qimux_instruction = buf[rd_ptr], combinational from the registered pointer: zero-latency head view.
  - Transfer on vld_out & dup_rdy: rd_ptr+1, count−1.
  - Held instruction stays stable while vld_out=1 and dup_rdy=0.
  - No capture in DUP.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. qed_full = (count==DEPTH).
- Latency: first replayed instruction is visible the cycle after the ORIG→DUP edge.
- stall_IF=1 holds all state except async reset and the ena=0 clear.

Optional Feature:
- Macro: QED_CTRL_SYNC_EN.
- Defined: in ORIG, a captured instruction with opcode 1100011, 1101111, 1100111 or 1110011 (branch/jal/jalr/system) is not stored. Instead the block forces ORIG→DUP on that edge when count>0, so duplicates complete before control flow. If count==0 it is simply not stored and the block stays in ORIG.
- Undefined: all valid instructions are captured; only exec_dup or full trigger DUP.

Test Plan:
- Reset mid-replay: in DUP with count=3, rst=0 → next sample shows vld_out=0, qed_count=0, qed_mode_dup=0, state IDLE; after rst=1 and ena=1 → ORIG.
- Capture 0x00100093, 0x00208113, 0x00310193, then exec_dup=1 with dup_rdy=1 → vld_out high 3 consecutive cycles emitting the same three words in order, then qed_mode_dup=0 and count=0.
- DEPTH=8, AUTO_SWITCH=1, 8 captures without exec_dup → qed_full=1 and qed_mode_dup=1 on the 8th capture edge. The 9th ifu_qed_vld is ignored; replay emits exactly 8 words, with wrap verified on a second batch of 8.
- dup_rdy=0 for 4 cycles during replay → qic_qimux_instruction constant, count constant; stall_IF=1 during replay → vld_out=0, no pointer movement.
- exec_dup=1 with count=0 → stays ORIG; exec_dup coincident with a capture at count=2 → replay emits 3 entries.
- With QED_CTRL_SYNC_EN: capture 2 ALU ops then 0x0000006F (jal) → immediate DUP replaying 2 entries; jal never appears on the replay output. Without the macro, the jal is replayed as the 3rd entry.
